inst_rom_loader: RTL
====================

// Module: inst_rom_loader
// PURPOSE
//  Instruction memory directly upstream of the core's fetch port (pc_reg/if_id).
//  - Loads a program from a byte stream after reset, then serves rom_addr/rom_ce reads combinationally.
//  - Holds the core in reset (cpu_rst) until a load completes.
//  - Allows a later reload without a global reset.
// PARAMETERS
//  ADDR_WIDTH  10  word-index bits; capacity DEPTH = 2**ADDR_WIDTH 32-bit words
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   reset, asynchronous, active-high
//  ld_valid    in   1   byte-stream valid
//  ld_byte     in   8   byte-stream data
//  ld_ready    out  1   loader accepts a byte; transfer when ld_valid && ld_ready
//  reload      in   1   single-cycle request to reload; honoured only in RUN
//  rom_ce_i    in   1   core fetch enable (core rom_ce_o)
//  rom_addr_i  in   32  core fetch byte address (core rom_addr_o)
//  rom_data_o  out  32  instruction word to core rom_data_i
//  cpu_rst     out  1   reset for the core; high in every state except RUN
//  load_done   out  1   high in RUN
//  load_err    out  1   high in ERR
// BEHAVIOUR
//  Stream format, big-endian: N[15:8], N[7:0], then N words as 4 bytes each, MSB first.
//  States: HDR0 -> HDR1 -> DATA -> RUN; ERR (see CONFIGURATION for CSUM).
//  Reset (async): state=HDR0, word_cnt=0, byte_cnt=0, loaded=0, hdr=0.
//    Outputs during reset: ld_ready=1, cpu_rst=1, load_done=0, load_err=0, rom_data_o=0.
//    Memory array is not cleared.
//  HDR0: accept byte -> hdr[15:8]; go to HDR1.
//  HDR1: accept byte -> hdr[7:0]; then:
//    N=0 -> RUN;  N>DEPTH -> ERR;  otherwise -> DATA.
//    loaded is cleared on entry to HDR1.
//  DATA:
//    - Bytes shift into a 32-bit assembly register; byte_cnt counts 0..3.
//    - On the 4th byte, write mem[word_cnt] in the same cycle, word_cnt++, loaded=word_cnt+1.
//    - After word N: go to RUN (or CSUM when the macro is enabled).
//  ld_ready = 1 in HDR0/HDR1/DATA/CSUM; 0 in RUN/ERR. Bytes offered while ld_ready=0 are ignored.
//  RUN: cpu_rst=0 and load_done=1, both driven from registered state; cpu_rst falls the cycle after the last byte.
//  reload in RUN -> HDR0 next cycle: cpu_rst=1, load_done=0. reload outside RUN is ignored.
//  ERR is left only by rst.
//  Read port, combinational, zero latency (matches if_id capture of rom_data_i):
//    - rom_ce_i=0 -> rom_data_o=0.
//    - Otherwise idx = rom_addr_i[ADDR_WIDTH+1:2]; rom_addr_i[1:0] is ignored.
//    - rom_data_o = mem[idx] if (rom_addr_i>>2) < loaded, else 0 (NOP).
//    - Addresses beyond DEPTH words return 0; no wrap-around.
//    - The read port is live in all states; cpu_rst keeps the core quiescent during loading.
//  Reset mid-load: returns to HDR0; words already written stay in the array but are unreadable (loaded=0).
// CONFIGURATION
//  INST_ROM_CHECKSUM_EN defined:
//    - After the last data word, state CSUM accepts 4 bytes (big-endian) C.
//    - C == sum of all N words mod 2**32 -> RUN; mismatch -> ERR, loaded=0.
//    - N=0 also goes through CSUM (expects C=0).
//    - Checksum accumulator is reset in HDR1.
//  INST_ROM_CHECKSUM_EN undefined:
//    - No CSUM state, no accumulator; DATA -> RUN directly.
// TESTING
//  Stream 00 02 | 34 01 00 05 | 34 02 00 07 -> load_done=1, cpu_rst=0 one cycle after the last byte;
//    addr 0 -> 0x34010005, addr 4 -> 0x34020007, addr 8 -> 0.
//  Header 00 00 -> RUN immediately; any fetch returns 0.
//  Header N=DEPTH+1 (0x0401 at default) -> load_err=1, ld_ready=0, cpu_rst=1 permanently until rst.
//  Gaps in ld_valid mid-word (1 byte every 3 cycles) -> identical memory contents to back-to-back streaming.
//  rst asserted after 5 bytes, then a full 1-word load -> only word 0 readable; a second rst in RUN gives load_done=0 immediately (async).
//  CHECKSUM_EN: words 0x00000001, 0xFFFFFFFF with C=00 00 00 00 -> RUN; with C=00 00 00 01 -> ERR.
//  reload pulse in RUN -> cpu_rst=1 next cycle; new 1-word load replaces word 0; word 1 reads 0.

Source files
------------

// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   Instruction memory that sits in front of the core's fetch port. After
//   reset it loads a program from a byte stream and holds the core in reset
//   until the load completes. Once running it serves fetches combinationally.
//   A reload can be requested from RUN without a global reset.
//
//   Stream format (big-endian): N[15:8], N[7:0], then N words of 4 bytes, MSB first.
//
//   Optional feature macro: INST_ROM_CHECKSUM_EN
//     When defined, a 4-byte checksum (the sum of all words mod 2**32) follows
//     the data. A mismatching checksum sends the loader to ERR.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   ld_valid/ld_byte      byte stream in; ld_ready out; a byte transfers when valid && ready
//   reload                one-cycle reload request, honoured only in RUN
//   rom_ce_i/rom_addr_i   core fetch enable and byte address
//   rom_data_o            instruction word; 0 (NOP) when disabled or not loaded
//   cpu_rst               core reset, low only in RUN
//   load_done, load_err   high in RUN / high in ERR
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        reload,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam int          CW      = ADDR_WIDTH + 1;  // word counters must reach DEPTH itself
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_RUN, S_ERR, S_CSUM
  } state_t;

`ifdef INST_ROM_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_RUN;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_hdr;
  logic [CW-1:0] r_word_cnt;
  logic [1:0]    r_byte_cnt;
  logic [CW-1:0] r_loaded;
  logic [23:0]   r_asm;        // first three bytes of the word being assembled
  logic [31:0]   r_mem [DEPTH];
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]   r_csum;
`endif

  logic        w_accept;
  logic [15:0] w_n;
  logic [31:0] w_word;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_unused_addr;

  assign w_accept    = ld_valid && ld_ready;
  assign w_n         = {r_hdr[15:8], ld_byte};       // header value as it completes in HDR1
  assign w_word      = {r_asm, ld_byte};             // word as it completes on the 4th byte
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = ((32'(r_word_cnt) + 32'd1) == 32'(r_hdr));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR0;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HDR0: if (w_accept) w_state_next = S_HDR1;
      S_HDR1: begin
        if (w_accept) begin
          if (w_n == 16'd0)                w_state_next = S_AFTER_DATA;
          else if (32'(w_n) > DEPTH_W)     w_state_next = S_ERR;
          else                             w_state_next = S_DATA;
        end
      end
      S_DATA: if (w_accept && w_last_byte && w_last_word) w_state_next = S_AFTER_DATA;
      S_RUN:  if (reload) w_state_next = S_HDR0;
      S_ERR:  w_state_next = S_ERR;
`ifdef INST_ROM_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept && w_last_byte)
          w_state_next = (w_word == r_csum) ? S_RUN : S_ERR;
      end
`endif
      default: w_state_next = S_HDR0;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    ld_ready  = 1'b0;
    cpu_rst   = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_DATA, S_CSUM: ld_ready = 1'b1;
      S_RUN: begin
        cpu_rst   = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:   load_err = 1'b1;
      default: ld_ready = 1'b0;
    endcase
  end

  // Loader datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_loaded   <= '0;
      r_asm      <= '0;
`ifdef INST_ROM_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else if (w_accept) begin
      case (r_state)
        S_HDR0: begin
          r_hdr[15:8] <= ld_byte;
          r_loaded    <= '0;     // old program becomes unreadable as HDR1 is entered
        end
        S_HDR1: begin
          r_hdr[7:0] <= ld_byte;
          r_word_cnt <= '0;
          r_byte_cnt <= '0;
`ifdef INST_ROM_CHECKSUM_EN
          r_csum     <= '0;
`endif
        end
        S_DATA: begin
          r_asm      <= {r_asm[15:0], ld_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (w_last_byte) begin
            r_word_cnt <= r_word_cnt + CW'(1);
            r_loaded   <= r_word_cnt + CW'(1);
`ifdef INST_ROM_CHECKSUM_EN
            r_csum     <= r_csum + w_word;
`endif
          end
        end
`ifdef INST_ROM_CHECKSUM_EN
        S_CSUM: begin
          r_asm      <= {r_asm[15:0], ld_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (w_last_byte && (w_word != r_csum)) r_loaded <= '0;
        end
`endif
        default: r_byte_cnt <= r_byte_cnt;
      endcase
    end
  end

  // Memory write; the array is intentionally never cleared
  always_ff @(posedge clk) begin
    if ((r_state == S_DATA) && w_accept && w_last_byte)
      r_mem[r_word_cnt[ADDR_WIDTH-1:0]] <= w_word;
  end

  // Zero-latency fetch. Since loaded never exceeds DEPTH, the bound check also
  // blocks any address past the array, so there is no wrap-around.
  assign w_unused_addr = &{1'b0, rom_addr_i[1:0]};
  always_comb begin
    rom_data_o = 32'd0;
    if (rom_ce_i && ({2'b00, rom_addr_i[31:2]} < 32'(r_loaded)))
      rom_data_o = r_mem[rom_addr_i[ADDR_WIDTH+1:2]];
  end

endmodule
